main_memory: RTL and testbench

MAIN_MEMORY -- requirements
Module: main_memory

---
 rtl/mem_pkg.sv | 18 +
 rtl/read_pipe.sv | 42 ++++
 rtl/main_memory.sv | 73 +++++++
 tb/tb_main_memory.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared line-memory definitions, also used by processing_block.
package mem_pkg;
  localparam int W      = 512;
  localparam int ADDR_W = 16;
  localparam int LANE_W = 16;
  localparam int LANES  = 32;

  typedef logic [W-1:0] line_t;

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
  } load_req_t;

  function automatic line_t fill_line(logic [LANE_W-1:0] v);
    return {LANES{v}};
  endfunction
endpackage

// File: rtl/read_pipe.sv
// Fixed-latency valid+data delay line; the last data stage only moves on a
// valid so the output holds the most recent return.
module read_pipe #(
  parameter int W      = 512,
  parameter int STAGES = 2
) (
  input  logic         clock,
  input  logic         flush,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data
);
  logic [STAGES:1]         vld_pipe, vin;
  logic [STAGES:1][W-1:0]  data_pipe, din;

  always_comb begin
    vin    = '0;
    din    = '0;
    vin[1] = in_vld;
    din[1] = in_data;
    for (int i = 2; i <= STAGES; i++) begin
      vin[i] = vld_pipe[i-1];
      din[i] = data_pipe[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (flush) begin
      vld_pipe  <= '0;
      data_pipe <= '0;
    end else begin
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i] <= vin[i];
        if (i < STAGES || vin[i]) data_pipe[i] <= din[i];
      end
    end
  end

  assign out_vld  = vld_pipe[STAGES];
  assign out_data = data_pipe[STAGES];
endmodule

// File: rtl/main_memory.sv
// Line-wide main memory: edge/address-change triggered loads with fixed
// latency, write-first forwarding, host preload port and sticky range error.
module main_memory
  import mem_pkg::*;
#(
  parameter int W            = mem_pkg::W,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              load_ctrl,
  output logic [W-1:0]      load_data,
  output logic              load_valid,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [W-1:0]      write_data,
  input  logic              write_ctrl,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [W-1:0]      host_data,
  output logic              addr_err,
  output logic [15:0]       load_count,
  output logic [15:0]       write_count
);
  localparam int                IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   LIMIT = (ADDR_W+1)'(DEPTH);

  logic [W-1:0] mem [DEPTH];
  load_req_t    hist;
  logic         ld_ok, wr_ok, host_ok, accept, wr_hit;
  logic [W-1:0] rd_line;

  assign ld_ok   = {1'b0, load_addr}  < LIMIT;
  assign wr_ok   = {1'b0, write_addr} < LIMIT;
  assign host_ok = {1'b0, host_addr}  < LIMIT;

  // A held request re-fires only when the address moves.
  assign accept  = load_ctrl && (!hist.vld || load_addr != hist.addr);
  assign wr_hit  = write_ctrl && wr_ok && (write_addr == load_addr);
  assign rd_line = !ld_ok ? '0 :
                   wr_hit ? write_data : mem[load_addr[IDX_W-1:0]];

  // Storage deliberately has no reset; the write port beats the host port.
  always_ff @(posedge clock) begin
    if (write_ctrl && wr_ok)      mem[write_addr[IDX_W-1:0]] <= write_data;
    else if (host_we && host_ok)  mem[host_addr[IDX_W-1:0]]  <= host_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hist        <= '0;
      addr_err    <= 1'b0;
      load_count  <= '0;
      write_count <= '0;
    end else begin
      hist.vld <= load_ctrl;
      if (accept) hist.addr <= load_addr;
      if ((accept && !ld_ok) || (write_ctrl && !wr_ok)) addr_err <= 1'b1;
      if (accept && load_count != 16'hFFFF)      load_count  <= load_count + 16'd1;
      if (write_ctrl && write_count != 16'hFFFF) write_count <= write_count + 16'd1;
    end
  end

  read_pipe #(.W(W), .STAGES(READ_LATENCY)) u_read_pipe (
    .clock    (clock),
    .flush    (reset),
    .in_vld   (accept),
    .in_data  (rd_line),
    .out_vld  (load_valid),
    .out_data (load_data)
  );
endmodule

// File: tb/tb_main_memory.sv
// Scoreboard bench for main_memory: a reference model queues expected loads
// when requests are accepted and retires them when load_valid is due.
module tb_main_memory;
  import mem_pkg::*;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic              clock = 1'b0, reset = 1'b1;
  logic [ADDR_W-1:0] load_addr = '0, write_addr = '0, host_addr = '0;
  logic              load_ctrl = 1'b0, write_ctrl = 1'b0, host_we = 1'b0;
  logic [W-1:0]      write_data = '0, host_data = '0, load_data;
  logic              load_valid, addr_err;
  logic [15:0]       load_count, write_count;

  always #5 clock = ~clock;

  main_memory #(.W(W), .DEPTH(DEPTH), .READ_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .load_addr(load_addr), .load_ctrl(load_ctrl),
    .load_data(load_data), .load_valid(load_valid),
    .write_addr(write_addr), .write_data(write_data), .write_ctrl(write_ctrl),
    .host_we(host_we), .host_addr(host_addr), .host_data(host_data),
    .addr_err(addr_err), .load_count(load_count), .write_count(write_count)
  );

  typedef struct { logic [W-1:0] data; int due; } exp_t;
  exp_t         sb[$];
  logic [W-1:0] mdl [DEPTH];
  logic         m_last_ctrl = 1'b0, m_err = 1'b0;
  logic [15:0]  m_last_addr = '0, m_lc = '0, m_wc = '0;
  logic [W-1:0] m_held = '0;
  int           total = 0, bad = 0, edge_n = 0, vcount = 0, c0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit in_rng(logic [15:0] a);
    return int'(a) < DEPTH;
  endfunction

  // Model the cycle about to be clocked, clock it, then check outputs.
  task automatic tick();
    bit   acc;
    exp_t e;
    acc = !reset && load_ctrl && (!m_last_ctrl || load_addr != m_last_addr);
    if (acc) begin
      e.data = !in_rng(load_addr) ? '0 :
               (write_ctrl && write_addr == load_addr) ? write_data : mdl[load_addr[7:0]];
      e.due  = edge_n + LAT;
      sb.push_back(e);
    end
    if (write_ctrl && in_rng(write_addr))    mdl[write_addr[7:0]] = write_data;
    else if (host_we && in_rng(host_addr))   mdl[host_addr[7:0]]  = host_data;
    if (reset) begin
      m_last_ctrl = 1'b0; m_last_addr = '0; m_lc = '0; m_wc = '0;
      m_err = 1'b0; m_held = '0; sb.delete();
    end else begin
      m_last_ctrl = load_ctrl;
      if (acc) m_last_addr = load_addr;
      if (acc && m_lc != 16'hFFFF) m_lc++;
      if (write_ctrl && m_wc != 16'hFFFF) m_wc++;
      if ((acc && !in_rng(load_addr)) || (write_ctrl && !in_rng(write_addr))) m_err = 1'b1;
    end
    @(posedge clock);
    edge_n++;
    #1;
    if (load_valid === 1'b1) vcount++;
    if (sb.size() > 0 && sb[0].due == edge_n) begin
      chk("valid", load_valid, 1);
      m_held = sb[0].data;
      void'(sb.pop_front());
    end else begin
      chk("valid", load_valid, 0);
    end
    chk("data", load_data, m_held);
    chk("lcnt", load_count, m_lc);
    chk("wcnt", write_count, m_wc);
    chk("err", addr_err, m_err);
  endtask

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Preload lines 0..7 through the host port.
    host_we = 1'b1;
    for (int a = 0; a < 8; a++) begin
      host_addr = 16'(a);
      host_data = fill_line(a == 0 ? 16'h3e4d : a == 1 ? 16'h4000 : 16'(16'h1000 + a));
      tick();
    end
    host_we = 1'b0;

    // Held request on one address: exactly one return.
    c0 = vcount;
    load_addr = 16'd0; load_ctrl = 1'b1;
    repeat (4) tick();
    load_ctrl = 1'b0;
    repeat (3) tick();
    chk("held_pulses", vcount - c0, 1);
    chk("held_data", load_data, fill_line(16'h3e4d));
    chk("held_lcnt", load_count, 1);

    // Back-to-back accepts.
    c0 = vcount;
    load_ctrl = 1'b1; load_addr = 16'd0; tick();
    load_addr = 16'd1; tick();
    load_ctrl = 1'b0;
    repeat (3) tick();
    chk("b2b_pulses", vcount - c0, 2);
    chk("b2b_last", load_data, fill_line(16'h4000));

    // Write-first forwarding in the accept cycle.
    write_ctrl = 1'b1; write_addr = 16'd3; write_data = fill_line(16'h3f1a);
    load_ctrl = 1'b1; load_addr = 16'd3;
    tick();
    write_ctrl = 1'b0; load_ctrl = 1'b0;
    repeat (3) tick();
    chk("wfirst_data", load_data, fill_line(16'h3f1a));
    chk("wfirst_wcnt", write_count, 1);

    // Write port beats host port on a collision.
    host_we = 1'b1; host_addr = 16'd5; host_data = fill_line(16'h1111);
    write_ctrl = 1'b1; write_addr = 16'd5; write_data = fill_line(16'h2222);
    tick();
    host_we = 1'b0; write_ctrl = 1'b0;
    load_ctrl = 1'b1; load_addr = 16'd5; tick();
    load_ctrl = 1'b0;
    repeat (3) tick();
    chk("collide_data", load_data, fill_line(16'h2222));

    // A write after the accept does not disturb the in-flight result.
    load_ctrl = 1'b1; load_addr = 16'd1; tick();
    load_ctrl = 1'b0;
    write_ctrl = 1'b1; write_addr = 16'd1; write_data = fill_line(16'h7777);
    tick();
    write_ctrl = 1'b0;
    repeat (2) tick();
    chk("inflight_data", load_data, fill_line(16'h4000));

    // Reset with a load in flight: no return, storage survives.
    c0 = vcount;
    load_ctrl = 1'b1; load_addr = 16'd0; tick();
    load_ctrl = 1'b0; reset = 1'b1; tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_pulses", vcount - c0, 0);
    chk("rst_data", load_data, 0);
    load_ctrl = 1'b1; load_addr = 16'd0; tick();
    load_ctrl = 1'b0;
    repeat (3) tick();
    chk("rst_keep", load_data, fill_line(16'h3e4d));

    // Out-of-range load and write.
    load_ctrl = 1'b1; load_addr = 16'h0100; tick();
    load_ctrl = 1'b0;
    repeat (3) tick();
    chk("oob_data", load_data, 0);
    chk("oob_err", addr_err, 1);
    write_ctrl = 1'b1; write_addr = 16'h0200; write_data = fill_line(16'hdead);
    tick();
    write_ctrl = 1'b0;

    // Random traffic over the preloaded lines.
    for (int n = 0; n < 300; n++) begin
      load_ctrl  = $urandom_range(0, 3) != 0;
      load_addr  = 16'($urandom_range(0, 7));
      write_ctrl = $urandom_range(0, 3) == 0;
      write_addr = 16'($urandom_range(0, 7));
      write_data = {16{$urandom()}};
      host_we    = $urandom_range(0, 3) == 0;
      host_addr  = 16'($urandom_range(0, 7));
      host_data  = {16{$urandom()}};
      tick();
    end
    load_ctrl = 1'b0; write_ctrl = 1'b0; host_we = 1'b0;
    repeat (LAT + 2) tick();
    chk("sb_empty", sb.size(), 0);
    chk("err_sticky", addr_err, 1);

    reset = 1'b1; tick();
    reset = 1'b0; tick();
    chk("err_clr", addr_err, 0);
    chk("lcnt_clr", load_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
